checkpoint_seq_monitor: RTL and testbench

Synthesizable on-chip monitor that watches a W-bit status bus (e.g. mprj_io[31:16] checkbits) for a programmed ordered list of checkpoint values, with glitch filtering, per-checkpoint timeout and optional strict-order checking. It replaces ad-hoc wait/timeout sequences with a reusable block usable in user-project RTL and in benches. It reports pass/fail, the failing checkpoint and a one-cycle hit pulse per matched checkpoint.

---
 rtl/checkpoint_seq_monitor.sv | 212 +++++++++++++++++++++
 tb/tb_checkpoint_seq_monitor.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checkpoint_seq_monitor.sv
// Checkpoint sequence monitor: watches a status bus for an ordered list of
// programmed values. Values must be glitch-filtered (held STABLE edges) to count.
// Each gap between checkpoints can be bounded by a timeout.
// Strict mode fails on any unexpected stable value.
module checkpoint_seq_monitor #(
  parameter int unsigned W      = 16,
  parameter int unsigned N      = 8,
  parameter int unsigned TW     = 24,
  parameter int unsigned STABLE = 2
) (
  input  logic                 clock,
  input  logic                 RSTB,
  input  logic                 cfg_we,
  input  logic [$clog2(N)-1:0] cfg_idx,
  input  logic [W-1:0]         cfg_data,
  input  logic [$clog2(N):0]   cfg_count,
  input  logic [TW-1:0]        timeout_limit,
  input  logic                 strict,
  input  logic                 start,
  input  logic                 abort,
  input  logic [W-1:0]         watch_bus,
  output logic                 busy,
  output logic                 pass,
  output logic                 fail,
  output logic [1:0]           fail_code,
  output logic [$clog2(N)-1:0] cur_idx,
  output logic                 hit
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned SW = $clog2(STABLE + 1);

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_ORDER   = 2'd2;
  localparam logic [1:0] FC_BADCNT  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS, S_FAIL} state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_table [N];
  logic [W-1:0]   r_bus_q;
  logic [SW-1:0]  r_stab, w_stab_nxt;
  logic           r_stab_evt, w_evt_nxt;
  logic [W-1:0]   r_last_val, w_last_nxt;
  logic [TW-1:0]  r_timer, w_timer_nxt;
  logic [CW-1:0]  r_count, w_count_nxt;
  logic           r_strict, w_strict_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_pass, w_pass_nxt;
  logic           r_fail, w_fail_nxt;
  logic [1:0]     r_fail_code, w_code_nxt;
  logic [IW-1:0]  r_cur_idx, w_idx_nxt;
  logic           r_hit, w_hit_nxt;

  logic           w_bus_chg;
  logic [SW-1:0]  w_stab_inc;
  logic [SW-1:0]  w_stab_smp;
  logic           w_evt_smp;
  logic [W-1:0]   w_expect;
  logic           w_match;
  logic           w_order;
  logic           w_tmo;
  logic           w_last;
  logic           w_bad_cnt;

  // Stability counter: restarts on a bus change, saturates at STABLE; the
  // event flag marks only the edge on which the count first reaches STABLE
  assign w_bus_chg  = (watch_bus != r_bus_q);
  assign w_stab_inc = (r_stab == SW'(STABLE)) ? r_stab : r_stab + SW'(1);
  assign w_stab_smp = w_bus_chg ? SW'(1) : w_stab_inc;
  assign w_evt_smp  = (w_stab_smp == SW'(STABLE)) &&
                      (w_bus_chg || (r_stab != SW'(STABLE)));

  assign w_expect  = r_table[r_cur_idx];
  assign w_match   = r_stab_evt && (r_bus_q == w_expect);
  assign w_order   = r_strict && r_stab_evt && (r_bus_q != w_expect) &&
                     (r_bus_q != r_last_val);
  assign w_tmo     = (timeout_limit != '0) && (r_timer == timeout_limit - TW'(1));
  assign w_last    = (r_cur_idx == IW'(r_count - CW'(1)));
  assign w_bad_cnt = (cfg_count == '0) || (cfg_count > CW'(N));

  // Checkpoint table: writable only while no sequence is running
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      for (int unsigned i = 0; i < N; i++) r_table[i] <= '0;
    end else if (cfg_we && !r_busy) begin
      r_table[cfg_idx] <= cfg_data;
    end
  end

  // State register and all registered datapath/outputs
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      r_state     <= S_IDLE;
      r_bus_q     <= '0;
      r_stab      <= '0;
      r_stab_evt  <= 1'b0;
      r_last_val  <= '0;
      r_timer     <= '0;
      r_count     <= '0;
      r_strict    <= 1'b0;
      r_busy      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_code <= FC_NONE;
      r_cur_idx   <= '0;
      r_hit       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bus_q     <= watch_bus;
      r_stab      <= w_stab_nxt;
      r_stab_evt  <= w_evt_nxt;
      r_last_val  <= w_last_nxt;
      r_timer     <= w_timer_nxt;
      r_count     <= w_count_nxt;
      r_strict    <= w_strict_nxt;
      r_busy      <= w_busy_nxt;
      r_pass      <= w_pass_nxt;
      r_fail      <= w_fail_nxt;
      r_fail_code <= w_code_nxt;
      r_cur_idx   <= w_idx_nxt;
      r_hit       <= w_hit_nxt;
    end
  end

  // Next state: abort > match > order violation > timeout
  always_comb begin
    w_state_nxt  = r_state;
    w_stab_nxt   = w_stab_smp;
    w_evt_nxt    = w_evt_smp;
    w_last_nxt   = r_last_val;
    w_timer_nxt  = r_timer;
    w_count_nxt  = r_count;
    w_strict_nxt = r_strict;
    w_busy_nxt   = r_busy;
    w_pass_nxt   = r_pass;
    w_fail_nxt   = r_fail;
    w_code_nxt   = r_fail_code;
    w_idx_nxt    = r_cur_idx;
    w_hit_nxt    = 1'b0;

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_busy_nxt  = 1'b0;
      w_pass_nxt  = 1'b0;
      w_fail_nxt  = 1'b0;
      w_code_nxt  = FC_NONE;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          w_timer_nxt = r_timer + TW'(1);
          if (w_match) begin
            w_hit_nxt   = 1'b1;
            w_last_nxt  = r_bus_q;
            w_timer_nxt = '0;
            if (w_last) begin
              w_state_nxt = S_PASS;
              w_busy_nxt  = 1'b0;
              w_pass_nxt  = 1'b1;
            end else begin
              w_idx_nxt = r_cur_idx + IW'(1);
            end
          end else if (w_order) begin
            w_state_nxt = S_FAIL;
            w_busy_nxt  = 1'b0;
            w_fail_nxt  = 1'b1;
            w_code_nxt  = FC_ORDER;
          end else if (w_tmo) begin
            w_state_nxt = S_FAIL;
            w_busy_nxt  = 1'b0;
            w_fail_nxt  = 1'b1;
            w_code_nxt  = FC_TIMEOUT;
          end
        end
        default: begin
          if (start) begin
            w_pass_nxt = 1'b0;
            w_idx_nxt  = '0;
            if (w_bad_cnt) begin
              w_state_nxt = S_FAIL;
              w_busy_nxt  = 1'b0;
              w_fail_nxt  = 1'b1;
              w_code_nxt  = FC_BADCNT;
            end else begin
              w_state_nxt  = S_WAIT;
              w_busy_nxt   = 1'b1;
              w_fail_nxt   = 1'b0;
              w_code_nxt   = FC_NONE;
              w_timer_nxt  = '0;
              w_stab_nxt   = '0;
              w_evt_nxt    = 1'b0;
              w_last_nxt   = r_bus_q;
              w_count_nxt  = cfg_count;
              w_strict_nxt = strict;
            end
          end
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign fail_code = r_fail_code;
  assign cur_idx   = r_cur_idx;
  assign hit       = r_hit;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Scoreboard bench for checkpoint_seq_monitor: a segment-level reference model
// predicts hit/pass/fail events; a monitor pops and compares them as they occur.
module tb_checkpoint_seq_monitor;

  localparam int W = 16;
  localparam int N = 8;
  localparam int TW = 24;
  localparam int STB = 2;
  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;
  localparam int INF = 32'h3fff_ffff;

  localparam int EV_HIT  = 0;
  localparam int EV_PASS = 1;
  localparam int EV_FAIL = 2;

  typedef struct {
    int kind;
    int at;
    int idx;
    int code;
  } ev_t;

  logic          clock = 1'b0;
  logic          RSTB = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [W-1:0]  cfg_data = '0;
  logic [CW-1:0] cfg_count = '0;
  logic [TW-1:0] timeout_limit = '0;
  logic          strict = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  watch_bus = '0;
  logic          busy, pass, fail, hit;
  logic [1:0]    fail_code;
  logic [IW-1:0] cur_idx;

  checkpoint_seq_monitor #(.W(W), .N(N), .TW(TW), .STABLE(STB)) dut (
    .clock(clock), .RSTB(RSTB), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_data(cfg_data), .cfg_count(cfg_count), .timeout_limit(timeout_limit),
    .strict(strict), .start(start), .abort(abort), .watch_bus(watch_bus),
    .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
    .cur_idx(cur_idx), .hit(hit)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int  n_checks = 0;
  int  n_errors = 0;
  ev_t exp_q[$];

  // Scenario description
  logic [W-1:0] sc_tab [N];
  int           sc_count;
  bit           sc_strict;
  int           sc_limit;
  logic [W-1:0] sc_v0;
  logic [W-1:0] sc_val[$];
  int           sc_dur[$];
  int           sc_e[$];
  int           sc_gap, sc_tail, sc_ea, sc_we_mode;
  bit           sc_no_cfg;

  // Model end state
  bit m_busy, m_pass, m_fail;
  int m_code, m_idx;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint outs_now();
    return longint'({busy, pass, fail, fail_code, cur_idx});
  endfunction

  task automatic pop_check(input int kind);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: kind=%0d at edge %0d idx=%0d code=%0d, none expected",
               kind, cyc, cur_idx, fail_code);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.at != cyc || e.idx != int'(cur_idx) || e.code != int'(fail_code)) begin
        n_errors++;
        $display("FAIL event: got kind=%0d edge=%0d idx=%0d code=%0d, expected kind=%0d edge=%0d idx=%0d code=%0d",
                 kind, cyc, cur_idx, fail_code, e.kind, e.at, e.idx, e.code);
      end
    end
  endtask

  // Monitor: compares each hit pulse and each pass/fail rising edge
  logic pass_q = 1'b0, fail_q = 1'b0;
  always @(negedge clock) begin
    if (hit) pop_check(EV_HIT);
    if (pass && !pass_q) pop_check(EV_PASS);
    if (fail && !fail_q) pop_check(EV_FAIL);
    pass_q <= pass;
    fail_q <= fail;
  end

  function automatic void push_ev(input int kind, input int at, input int idx, input int code);
    ev_t e;
    e.kind = kind; e.at = at; e.idx = idx; e.code = code;
    exp_q.push_back(e);
  endfunction

  // Reference model over bus segments: a segment held >= STB edges becomes
  // visible STB edges after it first appears; deadlines run from the last match.
  task automatic model_run(input int s);
    logic [W-1:0] v, lv;
    int idx, tref, st, nx, x, d;
    bit done;
    m_busy = 1'b1; m_pass = 1'b0; m_fail = 1'b0; m_code = 0; m_idx = 0;
    if (sc_count == 0 || sc_count > N) begin
      push_ev(EV_FAIL, s, 0, 3);
      m_busy = 1'b0; m_fail = 1'b1; m_code = 3;
      return;
    end
    idx = 0; lv = sc_v0; tref = s; done = 1'b0;
    for (int k = 0; k <= sc_val.size() && !done; k++) begin
      v  = (k == 0) ? sc_v0 : sc_val[k-1];
      st = (k == 0) ? s + 1 : sc_e[k-1];
      nx = (k < sc_val.size()) ? sc_e[k] : INF;
      if (nx - st < STB) continue;
      x = st + STB;
      d = tref + sc_limit;
      if (sc_limit != 0 && d < x) break;
      if (x >= sc_ea) break;
      if (v == sc_tab[idx]) begin
        lv = v; tref = x;
        if (idx == sc_count - 1) begin
          push_ev(EV_HIT, x, idx, 0);
          push_ev(EV_PASS, x, idx, 0);
          m_busy = 1'b0; m_pass = 1'b1; done = 1'b1;
        end else begin
          idx++;
          push_ev(EV_HIT, x, idx, 0);
        end
      end else if (sc_strict && v != lv) begin
        push_ev(EV_FAIL, x, idx, 2);
        m_busy = 1'b0; m_fail = 1'b1; m_code = 2; done = 1'b1;
      end else if (sc_limit != 0 && d == x) begin
        push_ev(EV_FAIL, d, idx, 1);
        m_busy = 1'b0; m_fail = 1'b1; m_code = 1; done = 1'b1;
      end
    end
    if (!done && sc_limit != 0 && tref + sc_limit < sc_ea) begin
      push_ev(EV_FAIL, tref + sc_limit, idx, 1);
      m_busy = 1'b0; m_fail = 1'b1; m_code = 1;
    end
    m_idx = idx;
  endtask

  task automatic run_scenario(input string name);
    int s, k, e;
    @(negedge clock);
    watch_bus = sc_v0;
    if (!sc_no_cfg) begin
      for (int i = 0; i < N; i++) begin
        cfg_we = 1'b1; cfg_idx = IW'(i); cfg_data = sc_tab[i];
        @(negedge clock);
      end
    end
    cfg_we = 1'b0;
    repeat (3) @(negedge clock);
    start = 1'b1;
    cfg_count = CW'(sc_count);
    strict = sc_strict;
    timeout_limit = TW'(sc_limit);
    s = cyc + 1;
    sc_e.delete();
    e = s + 1 + sc_gap;
    for (int i = 0; i < sc_val.size(); i++) begin
      sc_e.push_back(e);
      e += sc_dur[i];
    end
    sc_ea = ((sc_val.size() == 0) ? s + 1 : sc_e[sc_e.size()-1]) + sc_tail;
    model_run(s);
    @(negedge clock);
    start = 1'b0;
    k = 0;
    for (int c = s; c < sc_ea - 1; c++) begin
      cfg_we = 1'b0;
      if (k < sc_val.size() && sc_e[k] - 1 == c) begin
        watch_bus = sc_val[k];
        k++;
        if (sc_we_mode == 1 || $urandom_range(0, 3) == 0) begin
          cfg_we = 1'b1;
          cfg_idx = IW'($urandom_range(0, N - 1));
          cfg_data = W'($urandom);
        end
      end
      @(negedge clock);
    end
    cfg_we = 1'b0;
    chk({name, "_final"}, outs_now(),
        longint'({m_busy, m_pass, m_fail, 2'(m_code), IW'(m_idx)}));
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    chk({name, "_abort_idle"}, outs_now(), 0);
  endtask

  task automatic set_t1_table();
    logic [W-1:0] t [6];
    t = '{16'hAB40, 16'h003E, 16'h0044, 16'h004A, 16'h0050, 16'hAB51};
    for (int i = 0; i < N; i++) sc_tab[i] = (i < 6) ? t[i] : '0;
    sc_count = 6; sc_strict = 1'b0; sc_limit = 0; sc_v0 = 16'h0000;
    sc_gap = 0; sc_tail = 10; sc_we_mode = 0; sc_no_cfg = 1'b0;
    sc_val.delete(); sc_dur.delete();
  endtask

  task automatic add_seg(input logic [W-1:0] v, input int d);
    sc_val.push_back(v);
    sc_dur.push_back(d);
  endtask

  task automatic t1_segs();
    add_seg(16'hAB40, 10); add_seg(16'h003E, 10); add_seg(16'h0044, 10);
    add_seg(16'h004A, 10); add_seg(16'h0050, 10); add_seg(16'hAB51, 10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] pool [6];
    logic [W-1:0] v, prev;
    int s, p, nseg, d;
    pool = '{16'h0000, 16'h1234, 16'hAB40, 16'h003E, 16'h5A5A, 16'hFFFF};

    #12;
    chk("reset_outputs", longint'({busy, pass, fail, fail_code, cur_idx, hit}), 0);
    repeat (2) @(negedge clock);
    RSTB = 1'b1;

    set_t1_table(); t1_segs(); run_scenario("seq6");
    set_t1_table(); t1_segs(); sc_we_mode = 1; run_scenario("seq6_we_in_wait");

    set_t1_table(); sc_limit = 100; sc_tail = 110;
    add_seg(16'hAB40, 10); add_seg(16'h003E, 10); add_seg(16'h0044, 10);
    run_scenario("timeout");

    set_t1_table(); sc_strict = 1'b1;
    add_seg(16'hAB40, 10); add_seg(16'h1234, 10);
    run_scenario("strict_on");
    set_t1_table(); sc_strict = 1'b0;
    add_seg(16'hAB40, 10); add_seg(16'h1234, 10);
    run_scenario("strict_off");

    set_t1_table(); sc_v0 = 16'h5A5A;
    add_seg(16'hAB40, 10); add_seg(16'h003E, 1); add_seg(16'h0000, 10);
    add_seg(16'h003E, 2); add_seg(16'h0000, 10);
    run_scenario("glitch");

    set_t1_table(); sc_count = 0; run_scenario("cnt_zero");
    set_t1_table(); sc_count = N + 1; run_scenario("cnt_over");

    // abort wins over a coincident start (bad count would otherwise fail)
    @(negedge clock);
    start = 1'b1; abort = 1'b1; cfg_count = '0;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    @(negedge clock);
    chk("abort_beats_start", longint'({busy, pass, fail, fail_code, cur_idx, hit}), 0);

    // asynchronous reset in the middle of a running sequence
    set_t1_table(); run_scenario("pre_reset_table");
    @(negedge clock);
    watch_bus = 16'h0000;
    repeat (2) @(negedge clock);
    start = 1'b1; cfg_count = CW'(6); strict = 1'b0; timeout_limit = '0;
    s = cyc + 1;
    push_ev(EV_HIT, s + 3, 1, 0);
    @(negedge clock);
    start = 1'b0;
    watch_bus = 16'hAB40;
    repeat (5) @(negedge clock);
    #2 RSTB = 1'b0;
    #1 chk("async_reset_outputs", longint'({busy, pass, fail, fail_code, cur_idx, hit}), 0);
    @(negedge clock);
    RSTB = 1'b1;
    chk("reset_pending", exp_q.size(), 0);
    exp_q.delete();

    // table is cleared by reset: entry 0 == 0 matches an idle zero bus
    for (int i = 0; i < N; i++) sc_tab[i] = '0;
    sc_count = 1; sc_strict = 1'b0; sc_limit = 0; sc_v0 = 16'h0000;
    sc_gap = 0; sc_tail = 6; sc_we_mode = 0; sc_no_cfg = 1'b1;
    sc_val.delete(); sc_dur.delete();
    run_scenario("table_after_reset");

    set_t1_table(); t1_segs(); run_scenario("restart_seq6");

    // randomized sequences
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) sc_tab[i] = pool[$urandom_range(0, 5)];
      sc_count = int'($urandom_range(1, N));
      if ($urandom_range(0, 9) == 0)
        sc_count = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(N + 1, 15));
      sc_v0 = pool[$urandom_range(0, 5)];
      sc_strict = 1'($urandom_range(0, 1));
      sc_limit = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(6, 40));
      sc_gap = int'($urandom_range(0, 3));
      sc_tail = int'($urandom_range(2, 12));
      sc_we_mode = 0; sc_no_cfg = 1'b0;
      sc_val.delete(); sc_dur.delete();
      prev = sc_v0; p = 0;
      nseg = int'($urandom_range(1, 3 * N + 2));
      for (int j = 0; j < nseg; j++) begin
        if ($urandom_range(0, 1) == 1 && p < N) v = sc_tab[p];
        else v = pool[$urandom_range(0, 5)];
        if (v == prev) v = v ^ 16'h0101;
        d = int'($urandom_range(1, 5));
        if (p < N && v == sc_tab[p] && d >= STB) p++;
        add_seg(v, d);
        prev = v;
      end
      run_scenario("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
